// File: rtl/vga_pkg.sv
// vga_pkg: shared raster timing for the VGA timing generator.
//   - 640x480@60 default timing constants (pixel counts per region).
//   - raster_total(): line/frame length from active + porches + sync.
//   - sync_start()/sync_end(): sync window bounds; end is exclusive.
package vga_pkg;

    localparam int VGA_H_ACTIVE  = 640;
    localparam int VGA_H_FP      = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BP      = 48;
    localparam int VGA_V_ACTIVE  = 480;
    localparam int VGA_V_FP      = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BP      = 33;
    localparam int VGA_HSYNC_POL = 0;
    localparam int VGA_VSYNC_POL = 0;
    localparam int VGA_CLK_DIV   = 4;
    localparam int VGA_COORD_W   = 10;

    function automatic int raster_total(input int active, input int fp,
                                        input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int sync_start(input int active, input int fp);
        return active + fp;
    endfunction

    function automatic int sync_end(input int active, input int fp, input int sync);
        return active + fp + sync;
    endfunction

endpackage

// File: rtl/clk_enable_div.sv
// clk_enable_div: pixel-clock prescaler producing a one-clk pix_tick.
//   clk      in  system clock
//   rst_n    in  asynchronous active-low reset
//   enable   in  1 = count; 0 = clear the prescaler and suppress ticks
//   pix_tick out high in the cycle where the prescaler sits on its last phase
module clk_enable_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic pix_tick
);

    // A one-bit counter is kept for CLK_DIV=1 so the decode stays uniform;
    // it never leaves 0, which makes pix_tick follow enable.
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next prescaler phase: wrap after the last phase, cleared while held.
    always_comb begin
        cnt_d = cnt_q;
        if (!enable) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Prescaler phase register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Gated by rst_n so the tick reads 0 during reset even when CLK_DIV=1.
    assign pix_tick = rst_n & enable & (cnt_q == CNT_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
//   clk          in  system clock
//   rst_n        in  asynchronous active-low reset
//   enable       in  1 = run; 0 = hold counters and outputs
//   Hsync/Vsync  out registered syncs, active level set by *_POL
//   PixelAddress out {X, Y}
//   video_on     out X < H_ACTIVE and Y < V_ACTIVE
//   pix_tick     out one-clk pulse per pixel period
//   line_start   out one-clk pulse when X becomes 0
//   frame_start  out one-clk pulse when X and Y both become 0
//   frame_count  out frame counter, bumped with each frame_start
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE  = VGA_H_ACTIVE,
    parameter int H_FP      = VGA_H_FP,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BP      = VGA_H_BP,
    parameter int V_ACTIVE  = VGA_V_ACTIVE,
    parameter int V_FP      = VGA_V_FP,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BP      = VGA_V_BP,
    parameter int HSYNC_POL = VGA_HSYNC_POL,
    parameter int VSYNC_POL = VGA_VSYNC_POL,
    parameter int CLK_DIV   = VGA_CLK_DIV,
    parameter int COORD_W   = VGA_COORD_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    output logic                   Hsync,
    output logic                   Vsync,
    output logic [2*COORD_W-1:0]   PixelAddress,
    output logic                   video_on,
    output logic                   pix_tick,
    output logic                   line_start,
    output logic                   frame_start,
    output logic [15:0]            frame_count
);

    localparam int H_TOTAL = raster_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = raster_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] X_ACT    = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] Y_ACT    = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_START = COORD_W'(sync_start(H_ACTIVE, H_FP));
    localparam logic [COORD_W-1:0] HS_END   = COORD_W'(sync_end(H_ACTIVE, H_FP, H_SYNC));
    localparam logic [COORD_W-1:0] VS_START = COORD_W'(sync_start(V_ACTIVE, V_FP));
    localparam logic [COORD_W-1:0] VS_END   = COORD_W'(sync_end(V_ACTIVE, V_FP, V_SYNC));
    localparam logic               HS_ON    = (HSYNC_POL != 0);
    localparam logic               VS_ON    = (VSYNC_POL != 0);

    logic                tick_s;
    logic [COORD_W-1:0]  x_q, x_d, y_q, y_d;
    logic                hsync_q, hsync_d, vsync_q, vsync_d;
    logic                video_on_q, video_on_d;
    logic                line_start_q, line_start_d;
    logic                frame_start_q, frame_start_d;
    logic [15:0]         frame_count_q, frame_count_d;

    clk_enable_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .pix_tick (tick_s)
    );

    // Raster position: advance X per tick, Y when X wraps.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (tick_s) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                if (y_q == Y_LAST) begin
                    y_d = '0;
                end else begin
                    y_d = y_q + 1'b1;
                end
            end else begin
                x_d = x_q + 1'b1;
            end
        end else begin
            x_d = x_q;
            y_d = y_q;
        end
    end

    // Decode from the next position so the registered flags line up with
    // PixelAddress in the same cycle; with no tick x_d/y_d equal the held
    // position, so syncs and video_on hold while strobes drop.
    always_comb begin
        hsync_d       = ((x_d >= HS_START) && (x_d < HS_END)) ? HS_ON : ~HS_ON;
        vsync_d       = ((y_d >= VS_START) && (y_d < VS_END)) ? VS_ON : ~VS_ON;
        video_on_d    = (x_d < X_ACT) && (y_d < Y_ACT);
        line_start_d  = tick_s && (x_d == '0);
        frame_start_d = line_start_d && (y_d == '0);
        if (frame_start_d) begin
            frame_count_d = frame_count_q + 16'd1;
        end else begin
            frame_count_d = frame_count_q;
        end
    end

    // Raster state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q           <= X_LAST;
            y_q           <= Y_LAST;
            hsync_q       <= ~HS_ON;
            vsync_q       <= ~VS_ON;
            video_on_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= 16'd0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign Hsync        = hsync_q;
    assign Vsync        = vsync_q;
    assign PixelAddress = {x_q, y_q};
    assign video_on     = video_on_q;
    assign pix_tick     = tick_s;
    assign line_start   = line_start_q;
    assign frame_start  = frame_start_q;
    assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
// Bench for vga_timing_gen: three instances (default 640x480/4, tiny 14x7/1
// active-high, 32x13/3) compared every cycle against a linear-position model,
// plus hand-computed literal checks on timing windows and periods.
module tb_vga_timing_gen;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        von;
        logic        tick;
        logic        ls;
        logic        fs;
        logic [15:0] fc;
    } obs_t;

    typedef struct {
        int ha, hfp, hs, hbp, va, vfp, vs, vbp, hpol, vpol, div;
    } cfg_t;

    logic       clk = 1'b0;
    logic [2:0] rst_v;
    logic [2:0] en_v;
    int         n_cmp;
    int         n_err;

    logic hs_a, vs_a, von_a, tick_a, ls_a, fs_a; logic [19:0] pa_a; logic [15:0] fc_a;
    logic hs_b, vs_b, von_b, tick_b, ls_b, fs_b; logic [19:0] pa_b; logic [15:0] fc_b;
    logic hs_c, vs_c, von_c, tick_c, ls_c, fs_c; logic [19:0] pa_c; logic [15:0] fc_c;

    always #5 clk = ~clk;

    vga_timing_gen u_a (
        .clk(clk), .rst_n(rst_v[0]), .enable(en_v[0]), .Hsync(hs_a), .Vsync(vs_a),
        .PixelAddress(pa_a), .video_on(von_a), .pix_tick(tick_a), .line_start(ls_a),
        .frame_start(fs_a), .frame_count(fc_a));

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1),
        .V_BP(1), .HSYNC_POL(1), .VSYNC_POL(1), .CLK_DIV(1), .COORD_W(10)
    ) u_b (
        .clk(clk), .rst_n(rst_v[1]), .enable(en_v[1]), .Hsync(hs_b), .Vsync(vs_b),
        .PixelAddress(pa_b), .video_on(von_b), .pix_tick(tick_b), .line_start(ls_b),
        .frame_start(fs_b), .frame_count(fc_b));

    vga_timing_gen #(
        .H_ACTIVE(20), .H_FP(3), .H_SYNC(4), .H_BP(5), .V_ACTIVE(6), .V_FP(2), .V_SYNC(2),
        .V_BP(3), .HSYNC_POL(0), .VSYNC_POL(0), .CLK_DIV(3), .COORD_W(10)
    ) u_c (
        .clk(clk), .rst_n(rst_v[2]), .enable(en_v[2]), .Hsync(hs_c), .Vsync(vs_c),
        .PixelAddress(pa_c), .video_on(von_c), .pix_tick(tick_c), .line_start(ls_c),
        .frame_start(fs_c), .frame_count(fc_c));

    function automatic cfg_t cfg_of(input int id);
        cfg_t c;
        case (id)
            0:       c = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 4};
            1:       c = '{8, 2, 2, 2, 4, 1, 1, 1, 1, 1, 1};
            default: c = '{20, 3, 4, 5, 6, 2, 2, 3, 0, 0, 3};
        endcase
        return c;
    endfunction

    function automatic obs_t get_obs(input int id);
        obs_t o;
        case (id)
            0:       o = {hs_a, vs_a, pa_a[19:10], pa_a[9:0], von_a, tick_a, ls_a, fs_a, fc_a};
            1:       o = {hs_b, vs_b, pa_b[19:10], pa_b[9:0], von_b, tick_b, ls_b, fs_b, fc_b};
            default: o = {hs_c, vs_c, pa_c[19:10], pa_c[9:0], von_c, tick_c, ls_c, fs_c, fc_c};
        endcase
        return o;
    endfunction

    // ---------------- behavioural model: linear raster position ----------------
    int m_pos   [3];
    int m_phase [3];
    int m_fc    [3];
    bit m_last  [3];

    function automatic int h_tot(input cfg_t c);
        return c.ha + c.hfp + c.hs + c.hbp;
    endfunction

    function automatic int v_tot(input cfg_t c);
        return c.va + c.vfp + c.vs + c.vbp;
    endfunction

    task automatic model_reset(input int id);
        cfg_t c = cfg_of(id);
        m_pos[id]   = h_tot(c) * v_tot(c) - 1;
        m_phase[id] = 0;
        m_fc[id]    = 0;
        m_last[id]  = 1'b0;
    endtask

    task automatic model_step(input int id);
        cfg_t c = cfg_of(id);
        int frame = h_tot(c) * v_tot(c);
        m_last[id] = 1'b0;
        if (!en_v[id]) begin
            m_phase[id] = 0;
        end else if (m_phase[id] == c.div - 1) begin
            m_phase[id] = 0;
            m_pos[id]   = (m_pos[id] + 1) % frame;
            m_last[id]  = 1'b1;
            if (m_pos[id] == 0) m_fc[id] = (m_fc[id] + 1) % 65536;
        end else begin
            m_phase[id] = m_phase[id] + 1;
        end
    endtask

    function automatic obs_t model_expect(input int id);
        cfg_t c = cfg_of(id);
        obs_t e;
        int   x = m_pos[id] % h_tot(c);
        int   y = m_pos[id] / h_tot(c);
        bit   hwin = (x >= c.ha + c.hfp) && (x < c.ha + c.hfp + c.hs);
        bit   vwin = (y >= c.va + c.vfp) && (y < c.va + c.vfp + c.vs);
        e.x    = 10'(x);
        e.y    = 10'(y);
        e.hs   = hwin ? (c.hpol != 0) : (c.hpol == 0);
        e.vs   = vwin ? (c.vpol != 0) : (c.vpol == 0);
        e.von  = (x < c.ha) && (y < c.va);
        e.tick = rst_v[id] && en_v[id] && (m_phase[id] == c.div - 1);
        e.ls   = m_last[id] && (x == 0);
        e.fs   = m_last[id] && (m_pos[id] == 0);
        e.fc   = 16'(m_fc[id]);
        return e;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Per-cycle compare of every instance against the model, away from posedge.
    always @(negedge clk) begin
        for (int id = 0; id < 3; id++) begin
            obs_t o;
            obs_t e;
            if (!rst_v[id]) model_reset(id);
            o = get_obs(id);
            e = model_expect(id);
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL model_dut%0d @%0t: got x=%0d y=%0d hs=%b vs=%b von=%b tick=%b ls=%b fs=%b fc=%0d expected x=%0d y=%0d hs=%b vs=%b von=%b tick=%b ls=%b fs=%b fc=%0d",
                         id, $time, o.x, o.y, o.hs, o.vs, o.von, o.tick, o.ls, o.fs, o.fc,
                         e.x, e.y, e.hs, e.vs, e.von, e.tick, e.ls, e.fs, e.fc);
            end
            if (rst_v[id]) model_step(id);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic bit hit(input obs_t o, input int sel, input int val);
        case (sel)
            0:       return o.ls;
            1:       return o.fs;
            2:       return (o.x == 10'(val));
            default: return (o.y == 10'(val));
        endcase
    endfunction

    task automatic wait_for(input int id, input int sel, input int val, input int budget,
                            input string name);
        int n = 0;
        while (!hit(get_obs(id), sel, val) && n < budget) begin
            step(1);
            n++;
        end
        check(name, longint'(hit(get_obs(id), sel, val)), 1);
    endtask

    // From a strobe cycle (sel 0 = line, 1 = frame) to the next, counting
    // active-level syncs, video_on and ticks.
    task automatic measure(input int id, input int sel, input int budget, output int n,
                           output int hs_n, output int vs_n, output int vo_n, output int tk_n);
        cfg_t c = cfg_of(id);
        obs_t o;
        n = 0; hs_n = 0; vs_n = 0; vo_n = 0; tk_n = 0;
        do begin
            o = get_obs(id);
            if (o.hs == (c.hpol != 0)) hs_n++;
            if (o.vs == (c.vpol != 0)) vs_n++;
            if (o.von)  vo_n++;
            if (o.tick) tk_n++;
            step(1);
            n++;
        end while (!hit(get_obs(id), sel, 0) && n < budget);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t o;
        int   n, hs_n, vs_n, vo_n, tk_n, tk, f0;
        n_cmp = 0;
        n_err = 0;
        rst_v = 3'b000;
        en_v  = 3'b000;
        step(3);

        // Reset defaults.
        o = get_obs(0);
        check("rst_x_a", o.x, 799);
        check("rst_y_a", o.y, 524);
        check("rst_hs_a", o.hs, 1);
        check("rst_vs_a", o.vs, 1);
        check("rst_von_a", o.von, 0);
        check("rst_fc_a", o.fc, 0);
        o = get_obs(1);
        check("rst_hs_b_pol1", o.hs, 0);
        check("rst_vs_b_pol1", o.vs, 0);

        // Release: first tick after four enabled clks lands on (0,0).
        rst_v = 3'b111;
        en_v  = 3'b111;
        step(2);
        check("tick_early_a", tick_a, 0);
        step(1);
        check("tick_first_a", tick_a, 1);
        step(1);
        o = get_obs(0);
        check("first_x_a", o.x, 0);
        check("first_y_a", o.y, 0);
        check("first_von_a", o.von, 1);
        check("first_ls_a", o.ls, 1);
        check("first_fs_a", o.fs, 1);
        check("first_fc_a", o.fc, 1);
        step(1);
        check("ls_one_clk_a", ls_a, 0);
        check("fs_one_clk_a", fs_a, 0);

        // Horizontal timing on a full line.
        wait_for(0, 0, 0, 4000, "wait_ls_a");
        measure(0, 0, 4000, n, hs_n, vs_n, vo_n, tk_n);
        check("line_period_a", n, 3200);
        check("hsync_low_clks_a", hs_n, 384);
        check("video_on_clks_a", vo_n, 2560);
        check("ticks_per_line_a", tk_n, 800);

        // Enable hold at X=300.
        wait_for(0, 2, 300, 4000, "wait_x300_a");
        en_v[0] = 1'b0;
        tk = 0;
        for (int i = 0; i < 50; i++) begin
            tk += int'(tick_a);
            step(1);
        end
        check("hold_ticks_a", tk, 0);
        check("hold_x_a", get_obs(0).x, 300);
        en_v[0] = 1'b1;
        n = 0;
        while (get_obs(0).x != 10'd301 && n < 20) begin
            step(1);
            n++;
        end
        check("resume_latency_a", n, 4);

        // Asynchronous reset mid-frame.
        wait_for(0, 3, 3, 4000, "wait_y3_a");
        step(5);
        #2;
        rst_v[0] = 1'b0;
        #1;
        o = get_obs(0);
        check("async_x_a", o.x, 799);
        check("async_y_a", o.y, 524);
        check("async_hs_a", o.hs, 1);
        check("async_von_a", o.von, 0);
        check("async_fc_a", o.fc, 0);
        step(3);
        rst_v[0] = 1'b1;
        step(4);
        o = get_obs(0);
        check("rerelease_x_a", o.x, 0);
        check("rerelease_fc_a", o.fc, 1);

        // Small active-high config, one pixel per clk.
        wait_for(1, 1, 0, 200, "wait_fs_b");
        f0 = int'(fc_b);
        measure(1, 1, 200, n, hs_n, vs_n, vo_n, tk_n);
        check("frame_period_b", n, 98);
        check("hsync_high_clks_b", hs_n, 14);
        check("vsync_high_clks_b", vs_n, 14);
        check("video_on_clks_b", vo_n, 32);
        check("ticks_per_frame_b", tk_n, 98);
        check("fc_step_b", fc_b, (f0 + 1) % 65536);

        // Mid config: frame counter 1 then 2, vertical sync width.
        rst_v[2] = 1'b0;
        step(2);
        rst_v[2] = 1'b1;
        wait_for(2, 1, 0, 2000, "wait_fs_c");
        check("fc_first_c", fc_c, 1);
        measure(2, 1, 2000, n, hs_n, vs_n, vo_n, tk_n);
        check("frame_period_c", n, 1248);
        check("hsync_low_clks_c", hs_n, 156);
        check("vsync_low_clks_c", vs_n, 192);
        check("video_on_clks_c", vo_n, 360);
        check("ticks_per_frame_c", tk_n, 416);
        check("fc_second_c", fc_c, 2);

        step(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator; successor to the fixed 640x480 VGA controller. Generates Hsync/Vsync, packed pixel coordinates, an active-video flag, line/frame strobes and a frame counter from the system clock via an internal pixel-clock prescaler. Sits between the board clock and the pixel/framebuffer logic. All timing and polarity are parameters; a run/hold enable is added.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HSYNC_POL, 0, Hsync active level (0 = active-low)
VSYNC_POL, 0, Vsync active level (0 = active-low)
CLK_DIV, 4, system clocks per pixel (>=1)
COORD_W, 10, coordinate width; H_TOTAL-1 and V_TOTAL-1 must fit

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
enable  in  1  1 = run; 0 = hold all counters and outputs
Hsync  out  1  horizontal sync, registered
Vsync  out  1  vertical sync, registered
PixelAddress  out  2*COORD_W  {X, Y}: X in [2*COORD_W-1:COORD_W], Y in [COORD_W-1:0]
video_on  out  1  1 while X<H_ACTIVE and Y<V_ACTIVE
pix_tick  out  1  one-clk pulse per pixel period
line_start  out  1  one-clk pulse when X becomes 0
frame_start  out  1  one-clk pulse when X and Y both become 0
frame_count  out  16  completed-frame counter

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low, ports clk and rst_n.
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
- Reset values: prescaler 0; X = H_TOTAL-1, Y = V_TOTAL-1 (PixelAddress = {799,524} default); Hsync = ~HSYNC_POL; Vsync = ~VSYNC_POL; video_on 0; pix_tick 0; line_start 0; frame_start 0; frame_count 0.
- Prescaler counts 0..CLK_DIV-1 while enable=1. pix_tick is high in the clk cycle where prescaler = CLK_DIV-1. CLK_DIV=1: pix_tick = enable.
- On each pix_tick edge: X increments; at X=H_TOTAL-1 it wraps to 0 and Y increments; at Y=V_TOTAL-1 Y wraps to 0. First tick after reset lands on (0,0).
- Hsync, Vsync, video_on, line_start and frame_start are registered. They are computed from next-state counters, so they are aligned with PixelAddress in the same cycle (zero skew, no pipeline lag).
- Hsync active when H_ACTIVE+H_FP <= X < H_ACTIVE+H_FP+H_SYNC (656..751). Vsync active when V_ACTIVE+V_FP <= Y < V_ACTIVE+V_FP+V_SYNC (490..491). Vsync changes only at line boundaries.
- line_start: high for exactly one clk, the cycle after the update to X=0. frame_start: same cycle, only when Y=0 as well. line_start is also high whenever frame_start is high.
- frame_count increments on the frame_start cycle; wraps 65535 -> 0.
- enable=0: prescaler cleared to 0; counters, syncs, video_on and frame_count hold; pix_tick, line_start and frame_start forced 0. On re-enable, the next tick occurs CLK_DIV clks later and the raster resumes from the held position.
- rst_n asserted mid-frame: all outputs take reset values immediately (asynchronous). After release, the first tick comes CLK_DIV enabled clks later.

Decomposition:
- Package vga_pkg: 640x480@60 default timing constants, H_TOTAL/V_TOTAL computation, and sync-window start/end localparam formulas.
- One sub-module, clk_enable_div (prescaler with enable, parameter CLK_DIV, output pix_tick). The raster counters and decode stay in vga_timing_gen.

Test Plan:
- Reset, defaults: hold rst_n=0 -> PixelAddress={799,524}, Hsync=Vsync=1, video_on=0, frame_count=0. Release with enable=1 -> first pix_tick after 4 clks, then PixelAddress={0,0}, video_on=1, line_start=frame_start=1 for one clk.
- Horizontal timing, defaults: Hsync low from X=656 to X=751 (384 clks). line_start period 3200 clks. video_on high 2560 clks per active line.
- Vertical and frame: Vsync low exactly during Y=490..491 (6400 clks). frame_start period 1,680,000 clks. frame_count reads 1, then 2, at consecutive frame_start pulses.
- Enable hold: drop enable at X=300 for 50 clks -> PixelAddress frozen at X=300, no pix_tick. Re-raise enable -> X=301 appears 4 clks later; line period extended by exactly 50 clks plus prescaler-restart slack.
- Async reset mid-frame: assert rst_n=0 between clock edges at Y=200 -> outputs return to reset values before the next edge; frame_count=0.
- Small config: H 8/2/2/2, V 4/1/1/1, HSYNC_POL=1, VSYNC_POL=1, CLK_DIV=1 -> H_TOTAL=14, Hsync high for X=10..11, Vsync high for Y=5, frame_start every 98 clks, pix_tick constantly high while enabled.
